// File: rtl/mem_seq_pkg.sv
// Shared types for the frame sequencer: FSM states and the
// default-width output-buffer entry.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  localparam int unsigned C_DEF_DW = 32;

  typedef struct packed {
    logic [C_DEF_DW-1:0] data;
    logic                last;
  } buf_entry_t;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry registered stream buffer; head register drives the
// output directly, occupancy exported for upstream credit logic.
module axis_skid2
  import mem_seq_pkg::*;
#(
  parameter type T = buf_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  T           in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output T           out_data,
  output logic [1:0] occupancy
);

  T           head_q, head_d;
  T           tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic       pop;

  assign pop       = out_valid & out_ready;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign occupancy = occ_q;

  // Upstream guarantees no push into a full buffer without a pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({in_valid, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/mem_frame_sequencer.sv
// Streams a RAM window as AXI-Stream frames, repeated a programmed
// number of times or until stopped, with credit-based read issue.
module mem_frame_sequencer
  import mem_seq_pkg::*;
#(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_CNTWIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [G_ADDRWIDTH-1:0] cfg_base_addr,
  input  logic [7:0]             cfg_frame_len,
  input  logic [G_CNTWIDTH-1:0]  cfg_frame_count,
  output logic                   mem_rd,
  output logic [G_ADDRWIDTH-1:0] mem_raddr,
  input  logic [G_DATAWIDTH-1:0] mem_rdata,
  input  logic                   mem_rvalid,
  output logic [G_DATAWIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   sts_busy,
  output logic                   sts_done,
  output logic [G_CNTWIDTH-1:0]  sts_frames
);

  typedef struct packed {
    logic [G_DATAWIDTH-1:0] data;
    logic                   last;
  } entry_t;

  localparam logic [G_ADDRWIDTH-1:0] C_ADDR_MAX = G_ADDRWIDTH'(G_MEMDEPTH - 1);
  localparam logic [G_ADDRWIDTH-1:0] C_ADDR_ONE = 1;
  localparam logic [G_CNTWIDTH-1:0]  C_CNT_ONE  = 1;

  state_e                 state_q, state_d;
  logic [G_ADDRWIDTH-1:0] base_q, base_d;
  logic [G_ADDRWIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]             len_q, len_d;
  logic [7:0]             widx_q, widx_d;
  logic [G_CNTWIDTH-1:0]  count_q, count_d;
  logic [G_CNTWIDTH-1:0]  issued_q, issued_d;
  logic [G_CNTWIDTH-1:0]  frames_q, frames_d;
  logic                   stop_q, stop_d;
  logic                   inflight_q, inflight_d;
  logic                   tag_q, tag_d;
  logic                   done_q, done_d;

  logic       issue;
  logic       pop;
  logic       is_last;
  logic       stop_seen;
  logic       frames_done;
  logic [1:0] occ;
  logic [2:0] credit;
  logic       buf_valid;
  logic       buf_push;
  entry_t     buf_in;
  entry_t     buf_out;

  assign pop       = buf_valid & m_axis_tready;
  assign credit    = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign is_last   = (widx_q == len_q);
  assign stop_seen = stop_q | cfg_stop;
  assign frames_done = (count_q != '0) &&
                       (issued_q == count_q - C_CNT_ONE);

  // Reads only land in the buffer when we actually issued one;
  // stray rvalid after reset or in IDLE is dropped.
  assign buf_push    = mem_rvalid & inflight_q;
  assign buf_in.data = mem_rdata;
  assign buf_in.last = tag_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    raddr_d    = raddr_q;
    len_d      = len_q;
    widx_d     = widx_q;
    count_d    = count_q;
    issued_d   = issued_q;
    frames_d   = frames_q;
    stop_d     = stop_q;
    inflight_d = 1'b0;
    tag_d      = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;

    if (pop && buf_out.last && frames_q != {G_CNTWIDTH{1'b1}})
      frames_d = frames_q + C_CNT_ONE;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start && !cfg_stop) begin
          state_d  = S_RUN;
          base_d   = cfg_base_addr;
          raddr_d  = cfg_base_addr;
          len_d    = cfg_frame_len;
          count_d  = cfg_frame_count;
          widx_d   = 8'd0;
          issued_d = '0;
          frames_d = '0;
          stop_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (cfg_stop) stop_d = 1'b1;
        if (credit < 3'd2) begin
          issue      = 1'b1;
          inflight_d = 1'b1;
          tag_d      = is_last;
          if (is_last) begin
            widx_d   = 8'd0;
            raddr_d  = base_q;
            issued_d = issued_q + C_CNT_ONE;
            if (frames_done || stop_seen) state_d = S_DRAIN;
          end else begin
            widx_d  = widx_q + 8'd1;
            raddr_d = (raddr_q == C_ADDR_MAX) ? '0 : raddr_q + C_ADDR_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (occ == 2'd0 && !inflight_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      raddr_q    <= '0;
      len_q      <= 8'd0;
      widx_q     <= 8'd0;
      count_q    <= '0;
      issued_q   <= '0;
      frames_q   <= '0;
      stop_q     <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      raddr_q    <= raddr_d;
      len_q      <= len_d;
      widx_q     <= widx_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      frames_q   <= frames_d;
      stop_q     <= stop_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      done_q     <= done_d;
    end
  end

  axis_skid2 #(
    .T(entry_t)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (buf_push),
    .in_data  (buf_in),
    .out_valid(buf_valid),
    .out_ready(m_axis_tready),
    .out_data (buf_out),
    .occupancy(occ)
  );

  assign mem_rd        = issue;
  assign mem_raddr     = raddr_q;
  assign m_axis_tdata  = buf_out.data;
  assign m_axis_tlast  = buf_out.last;
  assign m_axis_tvalid = buf_valid;
  assign sts_busy      = (state_q != S_IDLE);
  assign sts_done      = done_q;
  assign sts_frames    = frames_q;

endmodule

// File: tb/tb_mem_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected beats from a RAM array
// model; a negedge monitor pops and compares every accepted beat.
module tb_mem_frame_sequencer;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic          cfg_stop;
  logic [AW-1:0] cfg_base_addr;
  logic [7:0]    cfg_frame_len;
  logic [CW-1:0] cfg_frame_count;
  logic          mem_rd;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          sts_busy;
  logic          sts_done;
  logic [CW-1:0] sts_frames;

  mem_frame_sequencer #(
    .G_DATAWIDTH(DW),
    .G_MEMDEPTH (DEPTH),
    .G_ADDRWIDTH(AW),
    .G_CNTWIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_frame_count(cfg_frame_count),
    .mem_rd         (mem_rd),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .sts_busy       (sts_busy),
    .sts_done       (sts_done),
    .sts_frames     (sts_frames)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];

  always @(posedge clk) begin
    mem_rvalid <= mem_rd;
    mem_rdata  <= ram[mem_raddr];
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int beats = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int acc_cnt = 0;
  int first_hs = 0;
  int last_hs = 0;
  int first_rd = -1;
  int first_tv = -1;
  int start_cyc = 0;
  int tr_pct = 100;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = ($urandom_range(99) < tr_pct);
    end
  end

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      rd_cnt     = 0;
      acc_cnt    = 0;
    end else begin
      if (sts_done) done_cnt++;
      if (mem_rd && first_rd < 0) first_rd = cyc;
      if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
      if (prev_stall) begin
        total++;
        if (!m_axis_tvalid || m_axis_tdata !== prev_d ||
            m_axis_tlast !== prev_l) begin
          bad++;
          $display("FAIL stall_hold got v=%b d=%0h l=%b required v=1 d=%0h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        acc_cnt++;
        if (beats == 0) first_hs = cyc;
        last_hs = cyc;
        beats++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat got d=%0h l=%b required no beat",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          b = exp_q.pop_front();
          if (m_axis_tdata !== b.d || m_axis_tlast !== b.l) begin
            bad++;
            $display("FAIL beat%0d got d=%0h l=%b required d=%0h l=%b",
                     beats, m_axis_tdata, m_axis_tlast, b.d, b.l);
          end
        end
      end
      if (mem_rd) begin
        rd_cnt++;
        total++;
        if (rd_cnt - acc_cnt > 2) begin
          bad++;
          $display("FAIL credit got outstanding=%0d required <=2",
                   rd_cnt - acc_cnt);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  task automatic check(input string nm, input longint got, input longint req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  task automatic push_expect(input int base, input int len, input int nfr);
    beat_t b;
    for (int f = 0; f < nfr; f++) begin
      for (int w = 0; w <= len; w++) begin
        b.d = ram[(base + w) % DEPTH];
        b.l = (w == len);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic start(input int base, input int len, input int count);
    @(posedge clk);
    #1;
    beats           = 0;
    first_rd        = -1;
    first_tv        = -1;
    start_cyc       = cyc;
    cfg_base_addr   = AW'(base);
    cfg_frame_len   = 8'(len);
    cfg_frame_count = CW'(count);
    cfg_start       = 1'b1;
    @(posedge clk);
    #1;
    cfg_start       = 1'b0;
    cfg_base_addr   = AW'($urandom);
    cfg_frame_len   = 8'($urandom);
    cfg_frame_count = CW'($urandom);
  endtask

  task automatic wait_done(input string nm, input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_timeout got no done after %0d cycles required done", nm, n);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end
  endtask

  task automatic finish_checks(input string nm, input int d0, input int nfr,
                               input int nbeats, input bit gapless);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_done_pulses"}, done_cnt - d0, 1);
    check({nm, "_beats"}, beats, nbeats);
    check({nm, "_leftover"}, exp_q.size(), 0);
    check({nm, "_frames"}, sts_frames, nfr);
    check({nm, "_busy"}, sts_busy, 0);
    check({nm, "_rd_latency"}, first_rd - start_cyc, 2);
    check({nm, "_tvalid_latency"}, first_tv - start_cyc, 4);
    if (gapless) check({nm, "_gapless"}, last_hs - first_hs, nbeats - 1);
    exp_q.delete();
  endtask

  task automatic run_cfg(input string nm, input int base, input int len,
                         input int count, input int pct);
    int d0;
    tr_pct = pct;
    push_expect(base, len, count);
    d0 = done_cnt;
    start(base, len, count);
    wait_done(nm, d0, 4000);
    finish_checks(nm, d0, count, (len + 1) * count, pct == 100);
  endtask

  initial begin
    int d0;
    int n;
    int base;
    rst             = 1'b1;
    cfg_start       = 1'b0;
    cfg_stop        = 1'b0;
    cfg_base_addr   = '0;
    cfg_frame_len   = '0;
    cfg_frame_count = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_raddr", mem_raddr, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", sts_busy, 0);
    check("rst_done", sts_done, 0);
    check("rst_frames", sts_frames, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_cfg("basic", 0, 3, 2, 100);
    run_cfg("wrap", 1022, 3, 1, 100);
    run_cfg("bp", $urandom_range(DEPTH - 1), 7, 3, 50);

    // continuous mode, stop raised once frame 2 is underway
    tr_pct = 60;
    base = $urandom_range(DEPTH - 1);
    push_expect(base, 4, 2);
    d0 = done_cnt;
    start(base, 4, 0);
    n = 0;
    while (beats < 6 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("stop_reach", beats >= 6, 1);
    #1 cfg_stop = 1'b1;
    @(posedge clk);
    #1 cfg_stop = 1'b0;
    wait_done("stop", d0, 2000);
    finish_checks("stop", d0, 2, 10, 1'b0);

    // reset in the middle of a frame
    tr_pct = 100;
    push_expect(100, 7, 1);
    start(100, 7, 1);
    n = 0;
    while (beats < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_busy", sts_busy, 0);
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_quiet", m_axis_tvalid, 0);
    run_cfg("after_rst", 100, 7, 1, 100);

    // start and stop together must be ignored
    @(posedge clk);
    #1;
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("coll_busy", sts_busy, 0);
      check("coll_mem_rd", mem_rd, 0);
      @(posedge clk);
      #1;
    end

    for (int r = 0; r < 4; r++) begin
      run_cfg($sformatf("rand%0d", r), $urandom_range(DEPTH - 1),
              $urandom_range(12), $urandom_range(1, 3),
              $urandom_range(30, 100));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
